if_id_skid_buffer: RTL and testbench

- Two-entry IF/ID pipeline buffer between Instruction_Fetch and the decode stage.
- Captures {pc, instruction} pairs from fetch using a valid/ready handshake.
- Presents them to decode in order.
- Absorbs one cycle of decode back-pressure without combinational ready paths.
- Supports a synchronous flush on a taken branch (pc_branch/select redirect).

---
 rtl/if_id_pkg.sv | 27 ++
 rtl/if_id_entry.sv | 53 +++++
 rtl/if_id_skid_buffer.sv | 175 +++++++++++++++++
 tb/tb_if_id_skid_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared constants, state encoding and entry type for the IF/ID skid buffer
package if_id_pkg;

    localparam int PC_W_DEFAULT    = 64;
    localparam int INSTR_W_DEFAULT = 32;

    // addi x0, x0, 0 : the canonical RISC-V no-op used as a decode bubble
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_e;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0]    pc;
        logic [INSTR_W_DEFAULT-1:0] instruction;
        logic                       misaligned;
    } entry_t;

    // An instruction fetched from a PC that is not word aligned
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return |pc_lo;
    endfunction

endpackage

// File: rtl/if_id_entry.sv
// rtl/if_id_entry.sv - load-enabled {pc, instruction, misaligned} register with asynchronous clear
module if_id_entry
    import if_id_pkg::*;
#(
    parameter int                    PC_W        = PC_W_DEFAULT,
    parameter int                    INSTR_W     = INSTR_W_DEFAULT,
    parameter logic [INSTR_W-1:0]    CLEAR_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PC_W-1:0]    d_pc,
    input  logic [INSTR_W-1:0] d_instruction,
    input  logic               d_misaligned,
    output logic [PC_W-1:0]    q_pc,
    output logic [INSTR_W-1:0] q_instruction,
    output logic               q_misaligned
);

    logic [PC_W-1:0]    pc_d,          pc_q;
    logic [INSTR_W-1:0] instruction_d, instruction_q;
    logic               misaligned_d,  misaligned_q;

    // Capture the new entry when loaded, otherwise keep the held one
    always_comb begin
        pc_d          = pc_q;
        instruction_d = instruction_q;
        misaligned_d  = misaligned_q;
        if (load) begin
            pc_d          = d_pc;
            instruction_d = d_instruction;
            misaligned_d  = d_misaligned;
        end
    end

    // Entry storage, cleared asynchronously on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= '0;
            instruction_q <= CLEAR_INSTR;
            misaligned_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign q_pc          = pc_q;
    assign q_instruction = instruction_q;
    assign q_misaligned  = misaligned_q;

endmodule

// File: rtl/if_id_skid_buffer.sv
// rtl/if_id_skid_buffer.sv - two-entry IF/ID skid buffer with flush; IF_ID_NOP_BUBBLE_EN makes idle outputs read a NOP
module if_id_skid_buffer
    import if_id_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instruction,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instruction,
    output logic               out_misaligned
);

    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = INSTR_W'(NOP_INSTR);
`ifdef IF_ID_NOP_BUBBLE_EN
    localparam logic [INSTR_W-1:0] HEAD_RESET_INSTR = BUBBLE_INSTR;
`else
    localparam logic [INSTR_W-1:0] HEAD_RESET_INSTR = '0;
`endif

    // Where the head register takes its next value from
    typedef enum logic [1:0] {
        SRC_IN     = 2'b00,
        SRC_SKID   = 2'b01,
        SRC_BUBBLE = 2'b10
    } head_src_e;

    state_e    state_d, state_q;
    logic      in_ready_d, in_ready_q;
    logic      out_valid_d, out_valid_q;
    logic      in_fire, out_fire;
    logic      head_load, skid_load;
    head_src_e head_src;
    logic      in_misaligned;

    logic [PC_W-1:0]    head_pc, skid_pc, head_pc_in;
    logic [INSTR_W-1:0] head_instr, skid_instr, head_instr_in;
    logic               head_mis, skid_mis, head_mis_in;

    // Handshakes use only registered ready/valid, so out_ready never reaches in_ready
    assign in_fire       = in_valid & in_ready_q;
    assign out_fire      = out_valid_q & out_ready;
    assign in_misaligned = pc_misaligned(in_pc[1:0]);

    // Next-state and register-load decisions; flush overrides every handshake
    always_comb begin
        state_d   = state_q;
        head_load = 1'b0;
        skid_load = 1'b0;
        head_src  = SRC_IN;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = ONE;
                        head_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d   = ONE;
                        head_load = 1'b1;
                        head_src  = SRC_SKID;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
`ifdef IF_ID_NOP_BUBBLE_EN
        // Going idle: replace the head with a NOP so decode sees a clean bubble
        if ((state_d == EMPTY) && (state_q != EMPTY)) begin
            head_load = 1'b1;
            head_src  = SRC_BUBBLE;
        end
`endif
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Select the data presented to the head register
    always_comb begin
        head_pc_in    = in_pc;
        head_instr_in = in_instruction;
        head_mis_in   = in_misaligned;
        case (head_src)
            SRC_SKID: begin
                head_pc_in    = skid_pc;
                head_instr_in = skid_instr;
                head_mis_in   = skid_mis;
            end
            SRC_BUBBLE: begin
                head_pc_in    = head_pc;
                head_instr_in = BUBBLE_INSTR;
                head_mis_in   = 1'b0;
            end
            default: begin
                head_pc_in    = in_pc;
                head_instr_in = in_instruction;
                head_mis_in   = in_misaligned;
            end
        endcase
    end

    // Occupancy FSM with registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    if_id_entry #(
        .PC_W        (PC_W),
        .INSTR_W     (INSTR_W),
        .CLEAR_INSTR (HEAD_RESET_INSTR)
    ) u_head (
        .clk           (clk),
        .reset         (reset),
        .load          (head_load),
        .d_pc          (head_pc_in),
        .d_instruction (head_instr_in),
        .d_misaligned  (head_mis_in),
        .q_pc          (head_pc),
        .q_instruction (head_instr),
        .q_misaligned  (head_mis)
    );

    if_id_entry #(
        .PC_W        (PC_W),
        .INSTR_W     (INSTR_W),
        .CLEAR_INSTR ('0)
    ) u_skid (
        .clk           (clk),
        .reset         (reset),
        .load          (skid_load),
        .d_pc          (in_pc),
        .d_instruction (in_instruction),
        .d_misaligned  (in_misaligned),
        .q_pc          (skid_pc),
        .q_instruction (skid_instr),
        .q_misaligned  (skid_mis)
    );

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_pc          = head_pc;
    assign out_instruction = head_instr;
    assign out_misaligned  = head_mis;

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb/tb_if_id_skid_buffer.sv - self-checking bench for if_id_skid_buffer against a queue model
module tb_if_id_skid_buffer;
    import if_id_pkg::*;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

`ifdef IF_ID_NOP_BUBBLE_EN
    localparam logic [31:0] IDLE_INSTR = NOP_INSTR;
    localparam bit          NOP_MODE   = 1'b1;
`else
    localparam logic [31:0] IDLE_INSTR = 32'h0;
    localparam bit          NOP_MODE   = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instruction;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instruction;
    logic               out_misaligned;

    always #5 clk = ~clk;

    if_id_skid_buffer #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_misaligned  (out_misaligned)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered list of held entries (capacity 2) plus what the outputs show
    entry_t           model_q[$];
    logic [PC_W-1:0]  disp_pc;
    logic [31:0]      disp_instr;
    logic             disp_mis;

    function automatic entry_t mk_entry(input logic [63:0] pc, input logic [31:0] instr);
        entry_t e;
        e.pc          = pc;
        e.instruction = instr;
        e.misaligned  = ((pc % 4) != 0);
        return e;
    endfunction

    task automatic model_reset();
        model_q.delete();
        disp_pc    = '0;
        disp_instr = IDLE_INSTR;
        disp_mis   = 1'b0;
    endtask

    task automatic model_edge(input logic iv, input logic [63:0] pc, input logic [31:0] instr,
                              input logic fl, input logic ordy);
        bit can_in;
        bit has_out;
        entry_t e;
        can_in  = (model_q.size() < 2);
        has_out = (model_q.size() > 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (has_out && ordy) e = model_q.pop_front();
            if (iv && can_in) model_q.push_back(mk_entry(pc, instr));
        end
        if (model_q.size() > 0) begin
            disp_pc    = model_q[0].pc;
            disp_instr = model_q[0].instruction;
            disp_mis   = model_q[0].misaligned;
        end else if (NOP_MODE) begin
            disp_instr = IDLE_INSTR;
            disp_mis   = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
        chk({tag, ".in_ready"},  64'(in_ready),  64'(model_q.size() < 2));
        chk({tag, ".out_pc"},    out_pc,         disp_pc);
        chk({tag, ".out_instr"}, 64'(out_instruction), 64'(disp_instr));
        chk({tag, ".out_mis"},   64'(out_misaligned),  64'(disp_mis));
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next falling edge
    task automatic cycle(input string tag, input logic iv, input logic [63:0] pc,
                         input logic [31:0] instr, input logic fl, input logic ordy);
        in_valid       = iv;
        in_pc          = pc;
        in_instruction = instr;
        flush          = fl;
        out_ready      = ordy;
        @(posedge clk);
        model_edge(iv, pc, instr, fl, ordy);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        in_pc          = '0;
        in_instruction = '0;
        flush          = 1'b0;
        out_ready      = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        chk("reset.instr_const", 64'(out_instruction), 64'(IDLE_INSTR));
        reset = 1'b0;
        @(negedge clk);
        check_all("reset_release");

        // Streaming with decode always ready
        cycle("stream0", 1'b1, 64'h0, 32'h00500093, 1'b0, 1'b1);
        chk("stream0.pc", out_pc, 64'h0);
        cycle("stream1", 1'b1, 64'h4, 32'h00A00113, 1'b0, 1'b1);
        chk("stream1.pc", out_pc, 64'h4);
        cycle("stream2", 1'b1, 64'h8, 32'h002081B3, 1'b0, 1'b1);
        chk("stream2.instr", 64'(out_instruction), 64'h002081B3);
        cycle("stream_drain", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

        // Back-pressure fills both entries
        cycle("bp0", 1'b1, 64'h10, 32'h11111111, 1'b0, 1'b0);
        cycle("bp1", 1'b1, 64'h14, 32'h22222222, 1'b0, 1'b0);
        chk("bp1.in_ready", 64'(in_ready), 64'h0);
        chk("bp1.pc", out_pc, 64'h10);
        cycle("bp_blocked", 1'b1, 64'h18, 32'h33333333, 1'b0, 1'b0);
        cycle("bp_rel0", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
        chk("bp_rel0.pc", out_pc, 64'h14);
        cycle("bp_rel1", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

        // Flush while full, with a simultaneous offer that must be dropped
        cycle("fl0", 1'b1, 64'h20, 32'h44444444, 1'b0, 1'b0);
        cycle("fl1", 1'b1, 64'h24, 32'h55555555, 1'b0, 1'b0);
        cycle("fl_flush", 1'b1, 64'h28, 32'h66666666, 1'b1, 1'b0);
        chk("fl_flush.out_valid", 64'(out_valid), 64'h0);
        chk("fl_flush.in_ready", 64'(in_ready), 64'h1);
        cycle("fl_idle", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

        // Simultaneous accept and consume while holding one entry
        cycle("sim0", 1'b1, 64'h30, 32'h77777777, 1'b0, 1'b1);
        cycle("sim1", 1'b1, 64'h34, 32'h88888888, 1'b0, 1'b1);
        chk("sim1.pc", out_pc, 64'h34);
        cycle("sim_drain", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);

        // Misaligned PC flag travels with its entry
        cycle("mis0", 1'b1, 64'h42, 32'h99999999, 1'b0, 1'b1);
        chk("mis0.flag", 64'(out_misaligned), 64'h1);
        cycle("mis1", 1'b1, 64'h44, 32'hAAAAAAAA, 1'b0, 1'b1);
        chk("mis1.flag", 64'(out_misaligned), 64'h0);
        cycle("mis_drain", 1'b0, 64'h0, 32'h0, 1'b0, 1'b1);
        chk("drain.instr", 64'(out_instruction), NOP_MODE ? 64'(NOP_INSTR) : 64'hAAAAAAAA);

        // Asynchronous reset in the middle of a cycle while full
        cycle("ar0", 1'b1, 64'h50, 32'hBBBBBBBB, 1'b0, 1'b0);
        cycle("ar1", 1'b1, 64'h54, 32'hCCCCCCCC, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_all("async_reset_release");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic        iv, fl, ordy;
            logic [63:0] pc;
            logic [31:0] instr;
            iv    = ($urandom_range(0, 9) < 7);
            ordy  = ($urandom_range(0, 9) < 6);
            fl    = ($urandom_range(0, 19) == 0);
            pc    = {$urandom, $urandom};
            instr = $urandom;
            cycle("rand", iv, pc, instr, fl, ordy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
